// File: rtl/z_xfer_ctrl_pkg.sv
// Shared definitions for the Z transfer sequencer: state encoding and default timeout.
// Consumed by z_xfer_ctrl and z_ctrl_wdog.
package z_xfer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ALU = 3'd1,
    CAPTURE  = 3'd2,
    REQ      = 3'd3,
    DRIVE_LO = 3'd4,
    DRIVE_HI = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 7;

  // The bus request stays up from arbitration through the last drive beat.
  function automatic logic holds_bus(state_t s);
    return (s == REQ) || (s == DRIVE_LO) || (s == DRIVE_HI);
  endfunction

endpackage

// File: rtl/z_ctrl_wdog.sv
// WAIT_ALU watchdog: counts stalled cycles and flags the cycle on which the limit is reached.
// Only instantiated when ZCTRL_TIMEOUT_EN is defined.
module z_ctrl_wdog #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic clk,
  input  logic clr,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the stalled cycle that brings the count up to LIMIT.
  assign o_expired = i_enable && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/z_xfer_ctrl.sv
// Z result capture and bus transfer sequencer (Moore FSM, outputs decoded from state only).
// Optional WAIT_ALU timeout enabled by defining ZCTRL_TIMEOUT_EN.
module z_xfer_ctrl
  import z_xfer_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic op_wide,
  input  logic alu_done,
  input  logic bus_gnt,
  output logic bus_req,
  output logic ZIn,
  output logic ZLowOut,
  output logic ZHighOut,
  output logic RzIn,
  output logic LOIn,
  output logic HIIn,
  output logic busy,
  output logic done,
  output logic err
);

  state_t r_state;
  state_t w_state_next;
  logic   r_wide;
  logic   w_expired;

`ifdef ZCTRL_TIMEOUT_EN
  logic r_err;
  logic w_wdog_en;
  logic w_wdog_clr;

  assign w_wdog_en  = (r_state == WAIT_ALU) && !alu_done;
  assign w_wdog_clr = (r_state != WAIT_ALU);

  z_ctrl_wdog #(
    .LIMIT (TIMEOUT_CYC),
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .clr       (clr),
    .i_clear   (w_wdog_clr),
    .i_enable  (w_wdog_en),
    .o_expired (w_expired)
  );

  // Remembers that the upcoming DONE was reached by timeout.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == WAIT_ALU) && !alu_done && w_expired;
    end
  end
`else
  localparam logic [31:0] CFG_UNUSED = 32'(TIMEOUT_CYC) ^ 32'(CNT_W);
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = CFG_UNUSED;
  assign w_expired    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_wide  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && start) begin
        r_wide <= op_wide;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (start) w_state_next = WAIT_ALU;
      WAIT_ALU: begin
        if (alu_done) begin
          w_state_next = CAPTURE;
        end else if (w_expired) begin
          w_state_next = DONE;
        end
      end
      CAPTURE:  w_state_next = REQ;
      REQ:      if (bus_gnt) w_state_next = DRIVE_LO;
      DRIVE_LO: w_state_next = r_wide ? DRIVE_HI : DONE;
      DRIVE_HI: w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req  = holds_bus(r_state);
    busy     = (r_state != IDLE) && (r_state != DONE);
    ZIn      = (r_state == CAPTURE);
    ZLowOut  = (r_state == DRIVE_LO);
    ZHighOut = (r_state == DRIVE_HI);
    RzIn     = (r_state == DRIVE_LO) && !r_wide;
    LOIn     = (r_state == DRIVE_LO) && r_wide;
    HIIn     = (r_state == DRIVE_HI);
    done     = (r_state == DONE);
`ifdef ZCTRL_TIMEOUT_EN
    err      = (r_state == DONE) && r_err;
`else
    err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_z_xfer_ctrl.sv
// Self-checking bench for z_xfer_ctrl: directed vector table, timeout sequence (when enabled),
// and random traffic checked against a timestamp-based transaction model.
module tb_z_xfer_ctrl;

  localparam int TO = 8;
`ifdef ZCTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Output vector order: {bus_req, ZIn, ZLowOut, ZHighOut, RzIn, LOIn, HIIn, busy, done, err}
  localparam logic [9:0] E_REQ  = 10'b10_0000_0000;
  localparam logic [9:0] E_ZIN  = 10'b01_0000_0000;
  localparam logic [9:0] E_ZLO  = 10'b00_1000_0000;
  localparam logic [9:0] E_ZHI  = 10'b00_0100_0000;
  localparam logic [9:0] E_RZ   = 10'b00_0010_0000;
  localparam logic [9:0] E_LO   = 10'b00_0001_0000;
  localparam logic [9:0] E_HI   = 10'b00_0000_1000;
  localparam logic [9:0] E_BUSY = 10'b00_0000_0100;
  localparam logic [9:0] E_DONE = 10'b00_0000_0010;
  localparam logic [9:0] E_ERR  = 10'b00_0000_0001;

  logic clk = 1'b0;
  logic clr, start, op_wide, alu_done, bus_gnt;
  logic bus_req, ZIn, ZLowOut, ZHighOut, RzIn, LOIn, HIIn, busy, done, err;

  always #5 clk = ~clk;

  z_xfer_ctrl #(
    .TIMEOUT_CYC (TO),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op_wide  (op_wide),
    .alu_done (alu_done),
    .bus_gnt  (bus_gnt),
    .bus_req  (bus_req),
    .ZIn      (ZIn),
    .ZLowOut  (ZLowOut),
    .ZHighOut (ZHighOut),
    .RzIn     (RzIn),
    .LOIn     (LOIn),
    .HIIn     (HIIn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic       clr;
    logic       start;
    logic       wide;
    logic       alu;
    logic       gnt;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   zin_cnt  = 0;
  int   txn      = 0;

  // Transaction model: a transfer is a set of cycle timestamps derived from when
  // start, alu_done and bus_gnt were seen; outputs follow from those timestamps.
  bit m_act = 1'b0;
  bit m_wide, m_to;
  int t0, t_cap, t_lo, t_done;

  function automatic logic [9:0] dut_vec();
    return {bus_req, ZIn, ZLowOut, ZHighOut, RzIn, LOIn, HIIn, busy, done, err};
  endfunction

  function automatic bit m_idle();
    return !m_act || (t_done >= 0 && cyc > t_done);
  endfunction

  function automatic logic [9:0] model_exp();
    logic [9:0] e;
    e = '0;
    if (m_idle() || cyc <= t0) return e;
    if (cyc == t_done) begin
      e = E_DONE | (m_to ? E_ERR : 10'd0);
    end else begin
      e = E_BUSY;
      if (cyc == t_cap) e |= E_ZIN;
      if (t_cap >= 0 && cyc > t_cap) e |= E_REQ;
      if (t_lo >= 0 && cyc == t_lo) e |= E_ZLO | (m_wide ? E_LO : E_RZ);
      if (t_lo >= 0 && m_wide && cyc == t_lo + 1) e |= E_ZHI | E_HI;
    end
    return e;
  endfunction

  task automatic model_update(input logic c, input logic s, input logic w,
                              input logic a, input logic g);
    if (c) begin
      m_act = 1'b0;
    end else if (m_idle()) begin
      m_act = s;
      if (s) begin
        t0 = cyc; m_wide = w; m_to = 1'b0;
        t_cap = -1; t_lo = -1; t_done = -1;
      end
    end else if (t_cap < 0 && !m_to) begin
      if (a) begin
        t_cap = cyc + 1;
      end else if (TO_EN && (cyc - t0) == TO) begin
        t_done = cyc + 1;
        m_to   = 1'b1;
      end
    end else if (t_cap >= 0 && t_lo < 0 && cyc > t_cap && g) begin
      t_lo   = cyc + 1;
      t_done = t_lo + (m_wide ? 2 : 1);
    end
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic w,
                      input logic a, input logic g);
    clr = c; start = s; op_wide = w; alu_done = a; bus_gnt = g;
    model_update(c, s, w, a, g);
    if (c) zin_cnt = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Model comparison, strobe invariants and the one-capture-per-done rule.
  task automatic check_cycle();
    chk("model", dut_vec(), model_exp());
    chk("inv_lo_hi_excl", 10'(ZLowOut && ZHighOut), 10'd0);
    chk("inv_load_excl", 10'($countones({RzIn, LOIn, HIIn}) > 1), 10'd0);
    chk("inv_zin_vs_out", 10'(ZIn && (ZLowOut || ZHighOut)), 10'd0);
    if (ZIn) zin_cnt++;
    if (done) begin
      chk("zin_per_done", 10'(zin_cnt), err ? 10'd0 : 10'd1);
      zin_cnt = 0;
      txn++;
      $display("txn %0d done err=%0b at cycle %0d", txn, err, cyc);
    end
  endtask

  function automatic void add(input logic c, input logic s, input logic w,
                              input logic a, input logic g, input logic [9:0] e);
    vec_t v;
    v.clr = c; v.start = s; v.wide = w; v.alu = a; v.gnt = g; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    // Narrow op, alu_done and bus_gnt tied high: minimum latency.
    add(0, 1, 0, 1, 1, '0);
    add(0, 0, 0, 1, 1, E_BUSY);
    add(0, 0, 0, 1, 1, E_BUSY | E_ZIN);
    add(0, 0, 0, 1, 1, E_BUSY | E_REQ);
    add(0, 0, 0, 1, 1, E_BUSY | E_REQ | E_ZLO | E_RZ);
    add(0, 0, 0, 1, 1, E_DONE);
    add(0, 0, 0, 0, 0, '0);
    // Wide op, late alu_done, late grant; starts in WAIT_ALU and DONE ignored.
    add(0, 1, 1, 0, 0, '0);
    add(0, 1, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 0, 0, E_BUSY);
    add(0, 0, 0, 1, 0, E_BUSY);
    add(0, 0, 0, 0, 0, E_BUSY | E_ZIN);
    add(0, 0, 0, 0, 0, E_BUSY | E_REQ);
    add(0, 0, 0, 0, 0, E_BUSY | E_REQ);
    add(0, 0, 0, 0, 1, E_BUSY | E_REQ);
    add(0, 0, 0, 0, 1, E_BUSY | E_REQ | E_ZLO | E_LO);
    add(0, 0, 0, 0, 1, E_BUSY | E_REQ | E_ZHI | E_HI);
    add(0, 1, 1, 0, 0, E_DONE);
    add(0, 0, 0, 0, 0, '0);
    add(0, 0, 0, 0, 0, '0);
    // clr for two cycles while in REQ, then a normal narrow run.
    add(0, 1, 0, 1, 0, '0);
    add(0, 0, 0, 1, 0, E_BUSY);
    add(0, 0, 0, 0, 0, E_BUSY | E_ZIN);
    add(1, 0, 0, 0, 0, E_BUSY | E_REQ);
    add(1, 0, 0, 0, 1, '0);
    add(0, 0, 0, 0, 1, '0);
    add(0, 1, 0, 1, 1, '0);
    add(0, 0, 0, 1, 1, E_BUSY);
    add(0, 0, 0, 1, 1, E_BUSY | E_ZIN);
    add(0, 0, 0, 1, 1, E_BUSY | E_REQ);
    add(0, 0, 0, 1, 1, E_BUSY | E_REQ | E_ZLO | E_RZ);
    add(0, 0, 0, 1, 1, E_DONE);
    // clr wins over a simultaneous start.
    add(1, 1, 1, 1, 1, '0);
    add(0, 0, 0, 0, 0, '0);
    add(0, 0, 0, 0, 0, '0);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_state", dut_vec(), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("vec[%0d]", i), dut_vec(), tbl[i].exp);
      check_cycle();
      step(tbl[i].clr, tbl[i].start, tbl[i].wide, tbl[i].alu, tbl[i].gnt);
    end
    check_cycle();

`ifdef ZCTRL_TIMEOUT_EN
    // alu_done never arrives: DONE with err exactly TO cycles after WAIT_ALU entry.
    step(0, 1, 1, 0, 1);
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("to_wait[%0d]", i), dut_vec(), E_BUSY);
      check_cycle();
      step(0, 0, 0, 0, 1);
    end
    chk("to_done", dut_vec(), E_DONE | E_ERR);
    check_cycle();
    step(0, 0, 0, 0, 0);
    chk("to_idle", dut_vec(), '0);
    check_cycle();
`endif

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1));
      check_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
